main_mem_mp: RTL and testbench
==============================

MAIN_MEM_MP -- requirements
Module: main_mem_mp

Interface
REQ-001 SHALL have parameter DW, default 16, data word width in bits.
REQ-002 SHALL have parameter AW, default 8, address width; DEPTH = 2**AW words.
REQ-003 SHALL have parameter RPORTS, default 2, number of read-only ports, range 1-8.
REQ-004 SHALL have parameter WIPE_ON_RST, default 1; 1 = clear the array after reset, 0 = skip the clear.
REQ-005 SHALL have port clk_i, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1, reset; asynchronous assert, active-low.
REQ-007 SHALL have port wipe_i, input, 1, synchronous request to clear the whole array to zero.
REQ-008 SHALL have port busy_o, output, 1, high while a wipe is in progress.
REQ-009 SHALL have port rw_val_i, input, 1, read/write port request valid.
REQ-010 SHALL have port rw_wen_i, input, 1, 1 = write, 0 = read.
REQ-011 SHALL have port rw_addr_i, input, AW, read/write port address.
REQ-012 SHALL have port rw_wdata_i, input, DW, write data.
REQ-013 SHALL have port rw_rdy_o, output, 1, read/write port can accept a request this cycle.
REQ-014 SHALL have port rw_rvalid_o, output, 1, rw_rdata_o valid this cycle.
REQ-015 SHALL have port rw_rdata_o, output, DW, read/write port read data.
REQ-016 SHALL have port r_val_i, input, RPORTS, per-read-port request valid.
REQ-017 SHALL have port r_addr_i, input, RPORTS*AW, packed read addresses; port k at bits [k*AW +: AW].
REQ-018 SHALL have port r_rdy_o, output, RPORTS, per-port accept.
REQ-019 SHALL have port r_rvalid_o, output, RPORTS, per-port read data valid.
REQ-020 SHALL have port r_rdata_o, output, RPORTS*DW, packed read data; port k at bits [k*DW +: DW].

Function
REQ-021 SHALL implement a two-state FSM, WIPE and RUN.
REQ-022 SHALL start in WIPE on reset release when WIPE_ON_RST=1, and in RUN when WIPE_ON_RST=0.
REQ-023 SHALL, in WIPE, write zero to address ptr each cycle, with ptr stepping 0 to DEPTH-1.
REQ-024 SHALL go WIPE->RUN in the cycle after ptr = DEPTH-1 is written; a wipe lasts exactly DEPTH cycles.
REQ-025 SHALL go RUN->WIPE, with ptr cleared to 0, on the cycle after wipe_i is sampled high.
REQ-026 SHALL ignore wipe_i while already in WIPE; the wipe in progress neither restarts nor extends.
REQ-027 SHALL drive busy_o = (state == WIPE); all rdy outputs = ~busy_o, combinational from state.
REQ-028 SHALL accept a request only when val and rdy are both high; requests made during WIPE are dropped, with no write and no rvalid.
REQ-029 SHALL, for an accepted write, update mem[rw_addr_i] at that clock edge; no rvalid follows a write.
REQ-030 SHALL have read latency of 1 cycle: rvalid is high, with data, in the cycle after an accepted read.
REQ-031 SHALL hold rdata from the last read while rvalid is low.
REQ-032 SHALL, when a read port reads the address the rw port writes in the same cycle, return the new write data (write-first forwarding).
REQ-033 SHALL allow reads of the same address from any number of ports in the same cycle, each returning identical data.
REQ-034 SHALL sustain one access per port per cycle: full throughput, no back-pressure in RUN.
REQ-035 SHALL make the data array storage-only: it is not cleared by rst_ni itself, only by the WIPE sequence.

Reset
REQ-036 SHALL, while rst_ni is low, hold: state = WIPE (RUN if WIPE_ON_RST=0), ptr = 0, all rvalid = 0, rdata = 0, busy_o = WIPE_ON_RST, rdy = ~busy_o.
REQ-037 SHALL, if rst_ni is asserted mid-wipe, restart the wipe from ptr 0 after release.
REQ-038 SHALL, if rst_ni is asserted mid-read, never produce the pending rvalid.

Verification
REQ-039 Scenario, power-up wipe: release reset with AW=8 -> busy_o high for exactly 256 cycles; afterwards every address reads 0.
REQ-040 Scenario, write then read: write 0xBEEF to address 0x10, then read it on port 1 -> r_rvalid_o[1] is high the next cycle with data 0xBEEF.
REQ-041 Scenario, forwarding: in one cycle, rw writes 0x1234 to 0x20 while port 0 reads 0x20 -> port 0 returns 0x1234.
REQ-042 Scenario, runtime wipe: fill 0xFFFF, pulse wipe_i for 1 cycle, issue reads during the wipe -> reads are dropped and busy_o is high for 256 cycles; afterwards all addresses read 0.
REQ-043 Scenario, reset mid-wipe: assert rst_ni low at wipe cycle 100 -> after release, busy_o is high for a fresh 256 cycles.
REQ-044 Scenario, parameter sweep: DW=32, AW=4, RPORTS=4, random traffic against a scoreboard -> no mismatches, and the wipe lasts 16 cycles.

Source files
------------

// File: rtl/main_mem_mp.sv
// Multi-port memory: one read/write port plus RPORTS read-only ports, 1-cycle read latency.
// A WIPE sequence zeroes the array one word per cycle after reset release or on wipe_i.
module main_mem_mp #(
    parameter int DW          = 16,
    parameter int AW          = 8,
    parameter int RPORTS      = 2,
    parameter int WIPE_ON_RST = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wipe_i,
    output logic                 busy_o,
    input  logic                 rw_val_i,
    input  logic                 rw_wen_i,
    input  logic [AW-1:0]        rw_addr_i,
    input  logic [DW-1:0]        rw_wdata_i,
    output logic                 rw_rdy_o,
    output logic                 rw_rvalid_o,
    output logic [DW-1:0]        rw_rdata_o,
    input  logic [RPORTS-1:0]    r_val_i,
    input  logic [RPORTS*AW-1:0] r_addr_i,
    output logic [RPORTS-1:0]    r_rdy_o,
    output logic [RPORTS-1:0]    r_rvalid_o,
    output logic [RPORTS*DW-1:0] r_rdata_o
);
    localparam int DEPTH = 2**AW;

    typedef enum logic {S_RUN = 1'b0, S_WIPE = 1'b1} state_t;
    localparam state_t RST_STATE = (WIPE_ON_RST != 0) ? S_WIPE : S_RUN;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          busy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RST_STATE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_WIPE: begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == LAST_ADDR) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                if (wipe_i) begin
                    state_d = S_WIPE;
                    ptr_d   = '0;
                end
            end
        endcase
    end

    assign busy     = (state_q == S_WIPE);
    assign busy_o   = busy;
    assign rw_rdy_o = ~busy;

    // The wipe and the rw port share the single write port of the array.
    logic          rw_acc, rw_rd_acc, wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    assign rw_acc    = rw_val_i & ~busy;
    assign rw_rd_acc = rw_acc & ~rw_wen_i;
    assign wr_en     = busy | (rw_acc & rw_wen_i);
    assign wr_addr   = busy ? ptr_q : rw_addr_i;
    assign wr_data   = busy ? '0 : rw_wdata_i;

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    logic          rw_rvalid_q;
    logic [DW-1:0] rw_rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rw_rvalid_q <= 1'b0;
            rw_rdata_q  <= '0;
        end else begin
            rw_rvalid_q <= rw_rd_acc;
            if (rw_rd_acc) begin
                rw_rdata_q <= mem_q[rw_addr_i];
            end
        end
    end

    assign rw_rvalid_o = rw_rvalid_q;
    assign rw_rdata_o  = rw_rdata_q;

    for (genvar gi = 0; gi < RPORTS; gi++) begin : g_rport
        logic          acc;
        logic [AW-1:0] addr;
        logic [DW-1:0] word;
        logic          rvalid_q;
        logic [DW-1:0] rdata_q;

        assign acc  = r_val_i[gi] & ~busy;
        assign addr = r_addr_i[gi*AW +: AW];
        // Write-first: a same-cycle write to this address is forwarded.
        assign word = (wr_en && (wr_addr == addr)) ? wr_data : mem_q[addr];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= acc;
                if (acc) begin
                    rdata_q <= word;
                end
            end
        end

        assign r_rdy_o[gi]           = ~busy;
        assign r_rvalid_o[gi]        = rvalid_q;
        assign r_rdata_o[gi*DW +: DW] = rdata_q;
    end

endmodule

// File: tb/tb_main_mem_mp.sv
// Self-checking bench for main_mem_mp: default instance (16b x 256, 2 read ports)
// plus a DW=32/AW=4/RPORTS=4 instance for the parameter sweep.
module tb_main_mem_mp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A: defaults ----------------
    logic        rst_n, wipe, busy, rw_val, rw_wen, rw_rdy, rw_rvalid;
    logic [7:0]  rw_addr;
    logic [15:0] rw_wdata, rw_rdata;
    logic [1:0]  r_val, r_rdy, r_rvalid;
    logic [15:0] r_addr;
    logic [31:0] r_rdata;

    main_mem_mp dut_a (
        .clk_i(clk), .rst_ni(rst_n), .wipe_i(wipe), .busy_o(busy),
        .rw_val_i(rw_val), .rw_wen_i(rw_wen), .rw_addr_i(rw_addr), .rw_wdata_i(rw_wdata),
        .rw_rdy_o(rw_rdy), .rw_rvalid_o(rw_rvalid), .rw_rdata_o(rw_rdata),
        .r_val_i(r_val), .r_addr_i(r_addr), .r_rdy_o(r_rdy),
        .r_rvalid_o(r_rvalid), .r_rdata_o(r_rdata)
    );

    // ---------------- instance B: parameter sweep ----------------
    logic         rst_nb, wipe_b, busy_b, rw_val_b, rw_wen_b, rw_rdy_b, rw_rvalid_b;
    logic [3:0]   rw_addr_b;
    logic [31:0]  rw_wdata_b, rw_rdata_b;
    logic [3:0]   r_val_b, r_rdy_b, r_rvalid_b;
    logic [15:0]  r_addr_b;
    logic [127:0] r_rdata_b;

    main_mem_mp #(.DW(32), .AW(4), .RPORTS(4), .WIPE_ON_RST(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_nb), .wipe_i(wipe_b), .busy_o(busy_b),
        .rw_val_i(rw_val_b), .rw_wen_i(rw_wen_b), .rw_addr_i(rw_addr_b), .rw_wdata_i(rw_wdata_b),
        .rw_rdy_o(rw_rdy_b), .rw_rvalid_o(rw_rvalid_b), .rw_rdata_o(rw_rdata_b),
        .r_val_i(r_val_b), .r_addr_i(r_addr_b), .r_rdy_o(r_rdy_b),
        .r_rvalid_o(r_rvalid_b), .r_rdata_o(r_rdata_b)
    );

    typedef struct {
        logic        rw_val, rw_wen;
        logic [7:0]  rw_addr;
        logic [15:0] rw_wdata;
        logic [1:0]  r_val;
        logic [7:0]  a0, a1;
        logic        e_rwv;
        logic [15:0] e_rwd;
        logic [1:0]  e_rv;
        logic [15:0] e_d0, e_d1;
    } vec_t;

    vec_t        tbl [8];
    logic [15:0] mm [256];
    logic [31:0] mb [16];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        rw_val = 1'b0; rw_wen = 1'b0; r_val = 2'b00; wipe = 1'b0;
    endtask

    // Counts cycles with busy high, checking that nothing is ready or returns data meanwhile.
    task automatic wipe_len_a(input string nm);
        int n, bad;
        n = 0; bad = 0;
        while (busy === 1'b1 && n < 1000) begin
            if (rw_rdy !== 1'b0 || r_rdy !== 2'b00 || rw_rvalid !== 1'b0 || r_rvalid !== 2'b00) bad++;
            n++;
            cyc();
        end
        if (rw_rvalid !== 1'b0 || r_rvalid !== 2'b00) bad++;
        chk({nm, "_len"}, 256'(n), 256'(256));
        chk({nm, "_quiet"}, 256'(bad), 256'(0));
        $display("wipe %s: busy for %0d cycles", nm, n);
        foreach (mm[i]) mm[i] = 16'h0;
    endtask

    task automatic read_all_zero_a(input string nm);
        for (int a = 0; a < 256; a++) begin
            rw_val = 1'b1; rw_wen = 1'b0; rw_addr = 8'(a);
            r_val = 2'b11; r_addr = {8'(255 - a), 8'(a)};
            cyc();
            chk(nm, {rw_rvalid, rw_rdata, r_rvalid, r_rdata}, {1'b1, 16'h0, 2'b11, 32'h0});
        end
        idle_a();
        $display("readback %s: 256 addresses checked", nm);
    endtask

    initial begin
        int n, bad;
        logic [1:0]   ev;
        logic [15:0]  ed [2];
        logic         e_rwv;
        logic [15:0]  e_rwd;
        logic         evb_rw;
        logic [31:0]  edb_rw;
        logic [3:0]   evb;
        logic [127:0] edb;
        logic [31:0]  rnd;

        tbl[0] = '{1'b1, 1'b1, 8'h10, 16'hBEEF, 2'b00, 8'h00, 8'h00, 1'b0, 16'h0000, 2'b00, 16'h0000, 16'h0000};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 16'h0000, 2'b10, 8'h00, 8'h10, 1'b0, 16'h0000, 2'b10, 16'h0000, 16'hBEEF};
        tbl[2] = '{1'b1, 1'b1, 8'h20, 16'h1234, 2'b01, 8'h20, 8'h00, 1'b0, 16'h0000, 2'b01, 16'h1234, 16'hBEEF};
        tbl[3] = '{1'b1, 1'b0, 8'h10, 16'h0000, 2'b11, 8'h10, 8'h10, 1'b1, 16'hBEEF, 2'b11, 16'hBEEF, 16'hBEEF};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 16'h0000, 2'b00, 8'h00, 8'h00, 1'b0, 16'hBEEF, 2'b00, 16'hBEEF, 16'hBEEF};
        tbl[5] = '{1'b1, 1'b1, 8'hFF, 16'h5A5A, 2'b11, 8'h00, 8'hFF, 1'b0, 16'hBEEF, 2'b11, 16'h0000, 16'h5A5A};
        tbl[6] = '{1'b1, 1'b0, 8'hFF, 16'h0000, 2'b00, 8'h00, 8'h00, 1'b1, 16'h5A5A, 2'b00, 16'h0000, 16'h5A5A};
        tbl[7] = '{1'b1, 1'b0, 8'h20, 16'h0000, 2'b11, 8'h20, 8'h20, 1'b1, 16'h1234, 2'b11, 16'h1234, 16'h1234};

        rst_n = 1'b0; rst_nb = 1'b0;
        idle_a(); rw_addr = '0; rw_wdata = '0; r_addr = '0;
        wipe_b = 1'b0; rw_val_b = 1'b0; rw_wen_b = 1'b0; rw_addr_b = '0;
        rw_wdata_b = '0; r_val_b = '0; r_addr_b = '0;
        repeat (3) cyc();

        chk("reset_outputs", {busy, rw_rdy, r_rdy, rw_rvalid, r_rvalid, rw_rdata, r_rdata},
            {1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 16'h0, 32'h0});
        rst_n = 1'b1;
        wipe_len_a("powerup");
        chk("run_ready", {busy, rw_rdy, r_rdy}, {1'b0, 1'b1, 2'b11});
        read_all_zero_a("powerup_zero");

        // Fill with ones, then wipe at run time with reads attempted throughout.
        for (int a = 0; a < 256; a++) begin
            rw_val = 1'b1; rw_wen = 1'b1; rw_addr = 8'(a); rw_wdata = 16'hFFFF;
            cyc();
        end
        rw_wen = 1'b0; rw_addr = 8'h77; r_val = 2'b01; r_addr = 16'h0077;
        cyc();
        chk("fill_readback", {rw_rvalid, rw_rdata, r_rvalid[0], r_rdata[15:0]},
            {1'b1, 16'hFFFF, 1'b1, 16'hFFFF});
        idle_a();
        wipe = 1'b1;
        cyc();
        wipe = 1'b0;
        rw_val = 1'b1; rw_wen = 1'b0; rw_addr = 8'h03; r_val = 2'b11; r_addr = 16'h0405;
        n = 0; bad = 0;
        while (busy === 1'b1 && n < 1000) begin
            if (rw_rvalid !== 1'b0 || r_rvalid !== 2'b00) bad++;
            wipe = (n == 50);
            n++;
            cyc();
        end
        wipe = 1'b0;
        if (rw_rvalid !== 1'b0 || r_rvalid !== 2'b00) bad++;
        chk("runtime_wipe_len", 256'(n), 256'(256));
        chk("runtime_wipe_dropped", 256'(bad), 256'(0));
        $display("wipe runtime: busy for %0d cycles, %0d stray rvalids", n, bad);
        idle_a();
        read_all_zero_a("runtime_zero");

        // Reset while a read is being presented: no rvalid may ever appear for it.
        rw_val = 1'b1; rw_wen = 1'b1; rw_addr = 8'h05; rw_wdata = 16'hABCD;
        cyc();
        rw_wen = 1'b0; r_val = 2'b11; r_addr = 16'h0505;
        cyc();
        chk("pre_reset_read", {rw_rvalid, rw_rdata, r_rvalid, r_rdata},
            {1'b1, 16'hABCD, 2'b11, 32'hABCDABCD});
        rst_n = 1'b0;
        #1;
        chk("reset_mid_read", {busy, rw_rdy, r_rdy, rw_rvalid, r_rvalid, rw_rdata, r_rdata},
            {1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 16'h0, 32'h0});
        repeat (2) cyc();
        rst_n = 1'b1;
        wipe_len_a("after_read_reset");
        idle_a();

        // Reset at wipe cycle 100 restarts a full wipe.
        wipe = 1'b1;
        cyc();
        wipe = 1'b0;
        repeat (100) cyc();
        chk("wipe_cycle100_busy", {busy, rw_rdy}, {1'b1, 1'b0});
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        wipe_len_a("mid_wipe_reset");
        read_all_zero_a("final_zero");

        for (int i = 0; i < 8; i++) begin
            rw_val = tbl[i].rw_val; rw_wen = tbl[i].rw_wen; rw_addr = tbl[i].rw_addr;
            rw_wdata = tbl[i].rw_wdata; r_val = tbl[i].r_val; r_addr = {tbl[i].a1, tbl[i].a0};
            if (tbl[i].rw_val && tbl[i].rw_wen) mm[tbl[i].rw_addr] = tbl[i].rw_wdata;
            cyc();
            chk($sformatf("vec%0d", i), {rw_rvalid, rw_rdata, r_rvalid, r_rdata[15:0], r_rdata[31:16]},
                {tbl[i].e_rwv, tbl[i].e_rwd, tbl[i].e_rv, tbl[i].e_d0, tbl[i].e_d1});
            $display("vec%0d: rw_rvalid=%0b rw_rdata=%h r_rvalid=%b r_rdata=%h",
                     i, rw_rvalid, rw_rdata, r_rvalid, r_rdata);
        end

        // Random traffic on instance A against the array model (write-first on read ports).
        e_rwd = 16'h1234; ed[0] = 16'h1234; ed[1] = 16'h1234;
        for (int c = 0; c < 400; c++) begin
            rnd = $urandom;
            rw_val = (rnd[1:0] != 2'b00); rw_wen = rnd[2];
            rw_addr = rnd[3] ? 8'($urandom_range(0, 7)) : 8'($urandom);
            rw_wdata = 16'($urandom);
            r_val = rnd[5:4];
            r_addr[7:0]  = rnd[6] ? 8'($urandom_range(0, 7)) : 8'($urandom);
            r_addr[15:8] = rnd[7] ? 8'($urandom_range(0, 7)) : 8'($urandom);
            if (rw_val && rw_wen) mm[rw_addr] = rw_wdata;
            e_rwv = rw_val && !rw_wen;
            if (e_rwv) e_rwd = mm[rw_addr];
            ev = r_val;
            if (r_val[0]) ed[0] = mm[r_addr[7:0]];
            if (r_val[1]) ed[1] = mm[r_addr[15:8]];
            cyc();
            chk("rand_a", {busy, rw_rvalid, rw_rdata, r_rvalid, r_rdata},
                {1'b0, e_rwv, e_rwd, ev, ed[1], ed[0]});
        end
        idle_a();
        $display("random A: 400 transactions checked");

        // Instance B: wipe length and random traffic across four read ports.
        rst_nb = 1'b1;
        n = 0;
        while (busy_b === 1'b1 && n < 1000) begin
            n++;
            cyc();
        end
        chk("sweep_wipe_len", 256'(n), 256'(16));
        $display("wipe sweep: busy for %0d cycles", n);
        foreach (mb[i]) mb[i] = 32'h0;
        edb_rw = 32'h0; edb = '0;
        for (int c = 0; c < 300; c++) begin
            rnd = $urandom;
            rw_val_b = (rnd[1:0] != 2'b00); rw_wen_b = rnd[2];
            rw_addr_b = 4'($urandom); rw_wdata_b = $urandom;
            r_val_b = rnd[7:4]; r_addr_b = 16'($urandom);
            if (rw_val_b && rw_wen_b) mb[rw_addr_b] = rw_wdata_b;
            evb_rw = rw_val_b && !rw_wen_b;
            if (evb_rw) edb_rw = mb[rw_addr_b];
            evb = r_val_b;
            for (int k = 0; k < 4; k++) begin
                if (r_val_b[k]) edb[k*32 +: 32] = mb[r_addr_b[k*4 +: 4]];
            end
            cyc();
            chk("rand_b", {busy_b, r_rdy_b, rw_rvalid_b, rw_rdata_b, r_rvalid_b, r_rdata_b},
                {1'b0, 4'hF, evb_rw, edb_rw, evb, edb});
        end
        rw_val_b = 1'b0; r_val_b = '0;
        $display("random B: 300 transactions checked");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
